// File: rtl/raster_fb_writer.sv
// Pixel sink between the rasterizer and the frame-buffer write port: a small FIFO
// absorbs the unthrottled pixel stream, and a sweep engine clears the whole frame on request.
module raster_fb_writer #(
  parameter int DEPTH     = 16,
  parameter int FB_PIXELS = 307200
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pix_valid,
  input  logic [18:0]              pix_addr,
  input  logic [3:0]               pix_color,
  input  logic                     line_done,
  input  logic                     clear_req,
  input  logic                     fb_ready,
  output logic                     fb_we,
  output logic [18:0]              fb_addr,
  output logic [3:0]               fb_data,
  output logic                     busy,
  output logic                     overflow,
  output logic                     clear_done,
  output logic [15:0]              line_count,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [18:0] LAST_ADDR = 19'(FB_PIXELS - 1);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    CLEAR_WAIT = 2'd1,
    CLEAR      = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [22:0]   mem_r [DEPTH];
  logic [AW-1:0] rd_ptr_r, wr_ptr_r, rd_next_s;
  logic [AW:0]   count_r, count_s;
  logic [18:0]   sweep_r, sweep_s;
  logic [22:0]   head_s;
  logic          full_s, push_s, pop_s, drop_s, addr_ok_s;
  logic          sweep_acc_s, sweep_last_s, fb_we_s;
  logic          fb_we_r, busy_r, overflow_r, clear_done_r;
  logic [18:0]   fb_addr_r;
  logic [3:0]    fb_data_r;
  logic [15:0]   line_count_r;

  // Next-state logic: FIFO bookkeeping, sweep progress and the next head to present.
  always_comb begin
    addr_ok_s    = (pix_addr <= LAST_ADDR);
    full_s       = (count_r == (AW+1)'(DEPTH));
    pop_s        = fb_we_r && fb_ready && (state_r != CLEAR);
    push_s       = pix_valid && addr_ok_s && (!full_s || pop_s);
    drop_s       = pix_valid && addr_ok_s && full_s && !pop_s;
    count_s      = count_r + (AW+1)'(push_s) - (AW+1)'(pop_s);
    rd_next_s    = rd_ptr_r + AW'(pop_s);
    sweep_acc_s  = (state_r == CLEAR) && fb_we_r && fb_ready;
    sweep_last_s = sweep_acc_s && (sweep_r == LAST_ADDR);

    state_s = state_r;
    case (state_r)
      RUN: begin
        if (clear_req) begin
          state_s = (count_s == '0) ? CLEAR : CLEAR_WAIT;
        end else begin
          state_s = RUN;
        end
      end
      CLEAR_WAIT: begin
        if (count_s == '0) begin
          state_s = CLEAR;
        end else begin
          state_s = CLEAR_WAIT;
        end
      end
      CLEAR: begin
        if (sweep_last_s) begin
          state_s = RUN;
        end else begin
          state_s = CLEAR;
        end
      end
      default: state_s = RUN;
    endcase

    sweep_s = sweep_r;
    if ((state_s == CLEAR) && (state_r != CLEAR)) begin
      sweep_s = 19'd0;
    end else if (sweep_acc_s && !sweep_last_s) begin
      sweep_s = sweep_r + 19'd1;
    end else begin
      sweep_s = sweep_r;
    end

    // A pixel pushed into an (effectively) empty FIFO is not in the array yet.
    if (push_s && ((count_r == '0) || ((count_r == (AW+1)'(1)) && pop_s))) begin
      head_s = {pix_addr, pix_color};
    end else begin
      head_s = mem_r[rd_next_s];
    end

    fb_we_s = (state_s == CLEAR) || (count_s != '0);
  end

  // FIFO storage array (not reset; validity is tracked by the pointers).
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_r[wr_ptr_r] <= {pix_addr, pix_color};
    end
  end

  // Control state, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= RUN;
      rd_ptr_r     <= '0;
      wr_ptr_r     <= '0;
      count_r      <= '0;
      sweep_r      <= 19'd0;
      fb_we_r      <= 1'b0;
      fb_addr_r    <= 19'd0;
      fb_data_r    <= 4'd0;
      busy_r       <= 1'b0;
      overflow_r   <= 1'b0;
      clear_done_r <= 1'b0;
      line_count_r <= 16'd0;
    end else begin
      state_r      <= state_s;
      rd_ptr_r     <= rd_next_s;
      wr_ptr_r     <= wr_ptr_r + AW'(push_s);
      count_r      <= count_s;
      sweep_r      <= sweep_s;
      fb_we_r      <= fb_we_s;
      busy_r       <= (count_s != '0) || (state_s != RUN);
      overflow_r   <= overflow_r || drop_s;
      clear_done_r <= sweep_last_s;
      if (sweep_last_s) begin
        line_count_r <= 16'd0;
      end else if (line_done) begin
        line_count_r <= line_count_r + 16'd1;
      end else begin
        line_count_r <= line_count_r;
      end
      if (state_s == CLEAR) begin
        fb_addr_r <= sweep_s;
        fb_data_r <= 4'd0;
      end else if (fb_we_s) begin
        fb_addr_r <= head_s[22:4];
        fb_data_r <= head_s[3:0];
      end else begin
        fb_addr_r <= fb_addr_r;
        fb_data_r <= fb_data_r;
      end
    end
  end

  assign fb_we      = fb_we_r;
  assign fb_addr    = fb_addr_r;
  assign fb_data    = fb_data_r;
  assign busy       = busy_r;
  assign overflow   = overflow_r;
  assign clear_done = clear_done_r;
  assign line_count = line_count_r;
  assign fifo_count = count_r;

endmodule

// File: tb/tb_raster_fb_writer.sv
// Directed bench for raster_fb_writer: stream, stall/overflow, full push+pop,
// address range, frame clear ordering/timing and reset during a sweep.
module tb_raster_fb_writer;
  localparam int FBP = 20000;

  logic        clk = 1'b0;
  logic        rst, pix_valid, line_done, clear_req, fb_ready;
  logic [18:0] pix_addr;
  logic [3:0]  pix_color;
  logic        fb_we, busy, overflow, clear_done;
  logic [18:0] fb_addr;
  logic [3:0]  fb_data;
  logic [15:0] line_count;
  logic [4:0]  fifo_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int cd_cyc = -1;
  logic [22:0] wr_q[$];
  int          wr_cyc[$];

  raster_fb_writer #(.DEPTH(16), .FB_PIXELS(FBP)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_addr(pix_addr),
    .pix_color(pix_color), .line_done(line_done), .clear_req(clear_req),
    .fb_ready(fb_ready), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .busy(busy), .overflow(overflow), .clear_done(clear_done),
    .line_count(line_count), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Log every accepted write with the cycle it completed in.
  always @(posedge clk) begin
    if (!rst && fb_we && fb_ready) begin
      wr_q.push_back({fb_addr, fb_data});
      wr_cyc.push_back(cyc);
    end
    if (clear_done) cd_cyc <= cyc;
    cyc <= cyc + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; pix_valid = 1'b0; pix_addr = 19'd0; pix_color = 4'd0;
    line_done = 1'b0; clear_req = 1'b0; fb_ready = 1'b0;
    ticks(2);
    rst = 1'b0;
    wr_q.delete();
    wr_cyc.delete();
  endtask

  initial begin
    logic [18:0] saddr [5];
    int errs, n, cd_cnt, base, injected;
    saddr[0] = 19'd0; saddr[1] = 19'd641; saddr[2] = 19'd1280;
    saddr[3] = 19'(FBP - 1); saddr[4] = 19'd12345;

    // Reset values
    do_reset();
    chk("rst_we", fb_we, 1'b0);       chk("rst_addr", fb_addr, 19'd0);
    chk("rst_data", fb_data, 4'd0);   chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", overflow, 1'b0);   chk("rst_cd", clear_done, 1'b0);
    chk("rst_lc", line_count, 16'd0); chk("rst_cnt", fifo_count, 5'd0);

    // Stream of five pixels, one per cycle
    fb_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pix_valid = 1'b1; pix_addr = saddr[i]; pix_color = 4'(i + 1);
      tick();
      if (i == 0) begin
        chk("lat_we", fb_we, 1'b1); chk("lat_addr", fb_addr, 19'd0); chk("lat_data", fb_data, 4'd1);
      end
    end
    pix_valid = 1'b0;
    ticks(8);
    chk("stream_n", wr_q.size(), 32'd5);
    errs = 0;
    for (int i = 0; i < 5 && i < wr_q.size(); i++)
      if (wr_q[i] !== {saddr[i], 4'(i + 1)}) errs++;
    chk("stream_order", errs, 32'd0);
    if (wr_q.size() == 5) chk("stream_tput", wr_cyc[4] - wr_cyc[0], 32'd4);
    chk("stream_cnt", fifo_count, 5'd0); chk("stream_busy", busy, 1'b0);
    chk("stream_ovf", overflow, 1'b0);

    // Fill to 16 while stalled, then push and pop in the same cycle
    do_reset();
    for (int i = 0; i < 16; i++) begin
      pix_valid = 1'b1; pix_addr = 19'(200 + i); pix_color = 4'(i + 1);
      tick();
    end
    pix_valid = 1'b0;
    chk("full_cnt", fifo_count, 5'd16); chk("full_ovf", overflow, 1'b0);
    chk("full_addr", fb_addr, 19'd200); chk("full_data", fb_data, 4'd1);
    fb_ready = 1'b1; pix_valid = 1'b1; pix_addr = 19'd216; pix_color = 4'd1;
    tick();
    pix_valid = 1'b0;
    chk("pp_cnt", fifo_count, 5'd16); chk("pp_ovf", overflow, 1'b0);
    ticks(20);
    chk("pp_n", wr_q.size(), 32'd17);
    errs = 0;
    for (int i = 0; i < 17 && i < wr_q.size(); i++)
      if (wr_q[i] !== {19'(200 + i), 4'(i + 1)}) errs++;
    chk("pp_order", errs, 32'd0);
    chk("pp_empty", fifo_count, 5'd0);

    // Overflow: 17 pixels into a stalled 16-deep FIFO
    do_reset();
    for (int i = 0; i < 17; i++) begin
      pix_valid = 1'b1; pix_addr = 19'(300 + i); pix_color = 4'(i + 3);
      tick();
    end
    pix_valid = 1'b0;
    chk("ovf_cnt", fifo_count, 5'd16); chk("ovf_flag", overflow, 1'b1);
    chk("ovf_addr", fb_addr, 19'd300); chk("ovf_data", fb_data, 4'd3);
    ticks(3);
    chk("stall_we", fb_we, 1'b1); chk("stall_addr", fb_addr, 19'd300);
    fb_ready = 1'b1;
    ticks(20);
    chk("ovf_n", wr_q.size(), 32'd16);
    errs = 0;
    for (int i = 0; i < 16 && i < wr_q.size(); i++)
      if (wr_q[i] !== {19'(300 + i), 4'(i + 3)}) errs++;
    chk("ovf_order", errs, 32'd0);
    chk("ovf_sticky", overflow, 1'b1);

    // Out-of-range addresses are silently dropped
    do_reset();
    fb_ready = 1'b1; pix_valid = 1'b1;
    pix_addr = 19'(FBP);     tick();
    pix_addr = 19'd307200;   tick();
    pix_addr = 19'h7FFFF;    tick();
    pix_valid = 1'b0;
    ticks(3);
    chk("oor_cnt", fifo_count, 5'd0); chk("oor_n", wr_q.size(), 32'd0);
    chk("oor_ovf", overflow, 1'b0);   chk("oor_we", fb_we, 1'b0);

    // Frame clear behind three queued pixels, with a pixel pushed mid-sweep
    do_reset();
    line_done = 1'b1; ticks(2); line_done = 1'b0;
    chk("lc_two", line_count, 16'd2);
    for (int i = 0; i < 3; i++) begin
      fb_ready = (i == 1); pix_valid = 1'b1; pix_addr = 19'(500 + i); pix_color = 4'(7 + i);
      tick();
    end
    pix_valid = 1'b0; fb_ready = 1'b0; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    cd_cnt = 0; injected = 0;
    for (n = 0; n < FBP + 200; n++) begin
      fb_ready = (n < 10) ? n[0] : 1'b1;
      if (injected == 0 && wr_q.size() == 5003) begin
        pix_valid = 1'b1; pix_addr = 19'd777; pix_color = 4'hA;
        line_done = 1'b1; clear_req = 1'b1; injected = 1;
      end else begin
        pix_valid = 1'b0; line_done = 1'b0; clear_req = 1'b0;
      end
      tick();
      if (clear_done) cd_cnt++;
    end
    chk("clr_n", wr_q.size(), 32'(FBP + 4));
    errs = 0;
    for (int i = 0; i < 3 && i < wr_q.size(); i++)
      if (wr_q[i] !== {19'(500 + i), 4'(7 + i)}) errs++;
    chk("clr_pre", errs, 32'd0);
    errs = 0;
    for (int i = 0; i < FBP && i + 3 < wr_q.size(); i++)
      if (wr_q[i + 3] !== {19'(i), 4'd0}) errs++;
    chk("clr_sweep", errs, 32'd0);
    chk("clr_done_n", cd_cnt, 32'd1);
    chk("clr_lc", line_count, 16'd0);
    base = FBP + 2;
    if (wr_q.size() == FBP + 4) begin
      chk("clr_post", wr_q[base + 1], {19'd777, 4'hA});
      chk("clr_post_t", wr_cyc[base + 1] - wr_cyc[base], 32'd1);
      chk("clr_done_t", cd_cyc - wr_cyc[base], 32'd1);
    end

    // Reset in the middle of a sweep from an empty FIFO
    do_reset();
    fb_ready = 1'b1; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    chk("sw_we", fb_we, 1'b1); chk("sw_addr0", fb_addr, 19'd0);
    chk("sw_data", fb_data, 4'd0); chk("sw_busy", busy, 1'b1);
    n = 0;
    while (fb_addr != 19'd1000 && n < 2000) begin tick(); n++; end
    chk("sw_reach", n, 32'd1000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_we", fb_we, 1'b0); chk("mr_busy", busy, 1'b0); chk("mr_cnt", fifo_count, 5'd0);
    cd_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (clear_done || fb_we) cd_cnt++;
    end
    chk("mr_quiet", cd_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/raster_fb_writer.md
# raster_fb_writer

Pixel sink for the rasterizer's output stream. Accepts one pixel per cycle (valid, 19-bit linear address, 4-bit colour) with no backpressure, buffers it in a small FIFO, and drains it into the frame-buffer memory write port, which may stall. Also performs a full-frame clear sweep on request and counts completed lines. Sits between the rasterizer and the frame-buffer RAM controller.

## Interface
- DEPTH, 16: FIFO entries; power of two, at least 2.
- FB_PIXELS, 307200: frame size (640x480); valid addresses are 0..FB_PIXELS-1.
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- pix_valid  in  1  pixel present this cycle (rasterizer goodPixel).
- pix_addr  in  19  linear pixel address (y*640 + x).
- pix_color  in  4  pixel colour.
- line_done  in  1  one-cycle pulse at the end of a line (rasterizer done).
- clear_req  in  1  one-cycle pulse requesting a frame clear.
- fb_ready  in  1  memory accepts a write this cycle.
- fb_we  out  1  write request.
- fb_addr  out  19  write address.
- fb_data  out  4  write data.
- busy  out  1  FIFO non-empty, or clear pending or in progress.
- overflow  out  1  sticky: at least one valid pixel was dropped because the FIFO was full.
- clear_done  out  1  one-cycle pulse when the clear sweep completes.
- line_count  out  16  number of line_done pulses since reset or last clear completion; wraps at 65535 to 0.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- **Push:** occurs when pix_valid=1, pix_addr<FB_PIXELS and the FIFO is not full.
  - Address >= FB_PIXELS: silently discarded; overflow is not set.
  - FIFO full with no pop in the same cycle: pixel discarded and overflow set to 1. overflow clears only on rst.
  - FIFO full with a pop in the same cycle: push accepted; occupancy stays DEPTH.
- **Write handshake:** a write is accepted in any cycle where fb_we=1 and fb_ready=1.
  - fb_addr and fb_data hold the current source value while fb_we=1 and fb_ready=0.
  - fb_we never drops without an accepted write.
- **State machine (states RUN, CLEAR_WAIT, CLEAR):**
  - RUN: fb_we = FIFO non-empty; fb_addr/fb_data come from the FIFO head; an accepted write pops. On clear_req, go to CLEAR_WAIT.
  - CLEAR_WAIT: same behaviour as RUN, which drains pixels queued before the request. When the FIFO is empty, go to CLEAR with the sweep counter at 0. If the FIFO is already empty when clear_req arrives, the next state is CLEAR directly.
  - CLEAR: fb_we=1, fb_addr = sweep counter, fb_data=0. Each accepted write increments the counter. The write accepted at address FB_PIXELS-1 returns the block to RUN, pulses clear_done on the following cycle and zeroes line_count.
  - During CLEAR, pixels keep being pushed into the FIFO (overflow rules unchanged). They are written after the clear completes.
  - clear_req received in CLEAR_WAIT or CLEAR is ignored.
- **line_count:** increments on each line_done. If line_done coincides with the zeroing on clear completion, zeroing wins.
- **Counter widths:**
  - Sweep counter: 19 bits, never exceeds FB_PIXELS-1.
  - FIFO pointers: $clog2(DEPTH) bits; they wrap naturally.

## Timing
- **Reset values:**
  - Outputs: fb_we=0, fb_addr=0, fb_data=0, busy=0, overflow=0, clear_done=0, line_count=0, fifo_count=0.
  - Internal: state RUN, FIFO empty.
- **Reset mid-operation:** aborts any sweep and discards FIFO contents. No write completes in the reset cycle.
- **Write latency:** a pixel pushed at edge N (FIFO previously empty) drives fb_we=1 with its address and data during cycle N+1.
- **Throughput:** one write per cycle while fb_ready=1.
- **FIFO ordering:** pixels are written in the order they were pushed.
- **Registered outputs:** fifo_count and busy reflect state after the current edge. busy falls in the cycle after the last accepted write.
- **Full-frame clear:** with fb_ready held at 1 and an empty FIFO, clear_req at edge N gives:
  - first sweep write (address 0) in cycle N+1;
  - last sweep write (address FB_PIXELS-1) in cycle N+FB_PIXELS;
  - clear_done high in cycle N+FB_PIXELS+1.

## Test plan
- **Stream:** push 5 pixels (addr 0, 641, 1280, 307199, 12345; colours 1..5) on consecutive cycles with fb_ready=1 -> 5 writes in the same order, first in the cycle after the first push; fifo_count returns to 0; overflow=0.
- **Backpressure and overflow:** hold fb_ready=0 and push 17 pixels with DEPTH=16 -> fifo_count=16, overflow=1, and the 17th pixel is never written. Then release fb_ready -> exactly 16 writes; fb_addr stays stable while stalled.
- **Full with simultaneous push and pop:** FIFO at 16, fb_ready=1 and pix_valid=1 in the same cycle -> push accepted, count stays 16, overflow stays 0.
- **Out-of-range address:** pix_addr=307200 and 0x7FFFF -> no push, no write, overflow=0.
- **Clear:** 3 pixels queued with fb_ready toggling 1/0, then clear_req -> the 3 pixels are written first; then 307200 writes of data 0 to addresses 0..307199 in order; clear_done pulses once; line_count=0. A pixel pushed mid-sweep is written immediately after the sweep ends.
- **Reset mid-clear:** assert rst at sweep address 1000 -> next cycle fb_we=0, busy=0, fifo_count=0, and no clear_done pulse.
